// File: rtl/cpu.sv
// rtl/cpu.sv - single-cycle RV32 ALU-subset core; CPU_MUL_EN enables the mul instruction
// Optional feature macro: CPU_MUL_EN (when undefined, the mul encoding is a NOP)

// Program counter: async reset to 0, advances one word per enabled clock
module pc_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [31:0] pc_o
);
  // Step by 4 while running; 32-bit wrap is natural
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     pc_o <= 32'd0;
    else if (en) pc_o <= pc_o + 32'd4;
  end
endmodule

// Instruction ROM: combinational word read, preload port tied off by the core
module instruction_memory (
  input  logic        clk,
  input  logic        load_en,
  input  logic [7:0]  load_addr,
  input  logic [31:0] load_data,
  input  logic [7:0]  addr,
  output logic [31:0] data
);
  logic [31:0] memory [0:255];

  // Optional word load; contents are not reset
  always_ff @(posedge clk) begin
    if (load_en) memory[load_addr] <= load_data;
  end

  assign data = memory[addr];
endmodule

// Register file: two combinational read ports, one write port, x0 hardwired to 0
module register_file (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);
  logic [31:0] register [0:31];

  // Writes to x0 are dropped; reads before the edge see the old value
  always_ff @(posedge clk) begin
    if (we && (waddr != 5'd0)) register[waddr] <= wdata;
  end

  assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : register[raddr1];
  assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : register[raddr2];
endmodule

// Core top: fetch, decode, execute and write back in one clock
module cpu (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] result;
  logic        result_valid;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic        unused_pc_bits;

  pc_reg PC (
    .clk  (clk_i),
    .rst  (rst_i),
    .en   (start_i),
    .pc_o (pc)
  );

  // Only bits [9:2] address the ROM, so higher PCs alias modulo 1024 bytes
  instruction_memory Instruction_Memory (
    .clk       (clk_i),
    .load_en   (1'b0),
    .load_addr (8'd0),
    .load_data (32'd0),
    .addr      (pc[9:2]),
    .data      (instr)
  );

  assign unused_pc_bits = ^{pc[31:10], pc[1:0]};

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};

  register_file Registers (
    .clk    (clk_i),
    .we     (start_i & ~rst_i & result_valid),
    .waddr  (rd),
    .wdata  (result),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // Decode and execute; anything unrecognised leaves result_valid low (NOP)
  always_comb begin
    result       = 32'd0;
    result_valid = 1'b0;
    case (opcode)
      7'b0110011: begin
        case ({funct7, funct3})
          10'b0000000_111: begin result = rs1_data & rs2_data;          result_valid = 1'b1; end
          10'b0000000_100: begin result = rs1_data ^ rs2_data;          result_valid = 1'b1; end
          10'b0000000_001: begin result = rs1_data << rs2_data[4:0];    result_valid = 1'b1; end
          10'b0000000_000: begin result = rs1_data + rs2_data;          result_valid = 1'b1; end
          10'b0100000_000: begin result = rs1_data - rs2_data;          result_valid = 1'b1; end
`ifdef CPU_MUL_EN
          10'b0000001_000: begin result = rs1_data * rs2_data;          result_valid = 1'b1; end
`endif
          default: begin result = 32'd0; result_valid = 1'b0; end
        endcase
      end
      7'b0010011: begin
        if (funct3 == 3'b000) begin
          result       = rs1_data + imm_i;
          result_valid = 1'b1;
        end else if ((funct3 == 3'b101) && (funct7 == 7'b0100000)) begin
          result       = $signed(rs1_data) >>> rs2;
          result_valid = 1'b1;
        end
      end
      default: begin
        result       = 32'd0;
        result_valid = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - randomized and directed self-checking bench for cpu against a reference model
module tb_cpu;
  logic clk;
  logic rst;
  logic start;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_reg  [32];
  logic [31:0] m_imem [256];
  logic [31:0] m_pc;

  cpu dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  // Reference: execute one instruction at the architectural level
  function automatic void model_exec();
    logic [31:0] ins;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [63:0] prod;
    logic [31:0] imm;
    bit          ok;
    ins = m_imem[m_pc[9:2]];
    a   = (ins[19:15] == 0) ? 32'd0 : m_reg[ins[19:15]];
    b   = (ins[24:20] == 0) ? 32'd0 : m_reg[ins[24:20]];
    imm = {{20{ins[31]}}, ins[31:20]};
    ok  = 0;
    res = 0;
    if (ins[6:0] == 7'b0110011) begin
      if (ins[31:25] == 7'b0000000 && ins[14:12] == 3'd7) begin res = a & b; ok = 1; end
      if (ins[31:25] == 7'b0000000 && ins[14:12] == 3'd4) begin res = a ^ b; ok = 1; end
      if (ins[31:25] == 7'b0000000 && ins[14:12] == 3'd1) begin res = a << (b % 32); ok = 1; end
      if (ins[31:25] == 7'b0000000 && ins[14:12] == 3'd0) begin res = a + b; ok = 1; end
      if (ins[31:25] == 7'b0100000 && ins[14:12] == 3'd0) begin res = a - b; ok = 1; end
`ifdef CPU_MUL_EN
      if (ins[31:25] == 7'b0000001 && ins[14:12] == 3'd0) begin
        prod = {32'd0, a} * {32'd0, b};
        res  = prod[31:0];
        ok   = 1;
      end
`endif
    end else if (ins[6:0] == 7'b0010011) begin
      if (ins[14:12] == 3'd0) begin res = a + imm; ok = 1; end
      if (ins[14:12] == 3'd5 && ins[31:25] == 7'b0100000) begin
        res = 32'($signed(a) >>> ins[24:20]);
        ok  = 1;
      end
    end
    if (ok && ins[11:7] != 0) m_reg[ins[11:7]] = res;
    m_pc = m_pc + 32'd4;
  endfunction

  task automatic tick();
    if (start && !rst) model_exec();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      dut.Instruction_Memory.memory[i] = 32'd0;
      m_imem[i] = 32'd0;
    end
  endtask

  task automatic put(input int idx, input logic [31:0] w);
    dut.Instruction_Memory.memory[idx] = w;
    m_imem[idx] = w;
  endtask

  task automatic set_reg(input int idx, input logic [31:0] v);
    dut.Registers.register[idx] = v;
    m_reg[idx] = v;
  endtask

  task automatic clear_regs();
    for (int i = 0; i < 32; i++) set_reg(i, 32'd0);
  endtask

  task automatic pulse_reset();
    rst = 1;
    #2;
    rst = 0;
    m_pc = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    start = 0;
    #1;
    n_checks++;
    if (dut.PC.pc_o !== 32'd0) begin
      n_errors++;
      $display("FAIL reset_pc: got %h expected 00000000", dut.PC.pc_o);
    end
    m_pc = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_pc_progression();
    clear_rom();
    clear_regs();
    pulse_reset();
    start = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (dut.PC.pc_o !== 32'(4 * k)) begin
        n_errors++;
        $display("FAIL pc_step%0d: got %h expected %h", k, dut.PC.pc_o, 32'(4 * k));
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.Registers.register[i] !== 32'd0) begin
        n_errors++;
        $display("FAIL pc_regs_zero x%0d: got %h expected 00000000", i, dut.Registers.register[i]);
      end
    end
  endtask

  task automatic test_addi_add();
    start = 0;
    clear_rom();
    clear_regs();
    put(0, i_type(12'd10, 5'd0, 3'd0, 5'd1));
    put(1, i_type(12'hFFD, 5'd0, 3'd0, 5'd2));
    put(2, r_type(7'd0, 5'd2, 5'd1, 3'd0, 5'd3));
    pulse_reset();
    start = 1;
    repeat (3) tick();
    n_checks++;
    if (dut.Registers.register[1] !== 32'd10) begin
      n_errors++; $display("FAIL addi_x1: got %h expected 0000000a", dut.Registers.register[1]);
    end
    n_checks++;
    if (dut.Registers.register[2] !== 32'hFFFFFFFD) begin
      n_errors++; $display("FAIL addi_x2: got %h expected fffffffd", dut.Registers.register[2]);
    end
    n_checks++;
    if (dut.Registers.register[3] !== 32'd7) begin
      n_errors++; $display("FAIL add_x3: got %h expected 00000007", dut.Registers.register[3]);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] exp [4:8];
    start = 0;
    clear_rom();
    clear_regs();
    set_reg(1, 32'd10);
    set_reg(2, 32'hFFFFFFFD);
    put(0, r_type(7'b0100000, 5'd1, 5'd2, 3'd0, 5'd4));
    put(1, r_type(7'd0, 5'd2, 5'd1, 3'd4, 5'd5));
    put(2, r_type(7'd0, 5'd2, 5'd1, 3'd7, 5'd6));
    put(3, r_type(7'd0, 5'd1, 5'd1, 3'd1, 5'd7));
    put(4, i_type({7'b0100000, 5'd1}, 5'd2, 3'd5, 5'd8));
    exp[4] = 32'hFFFFFFF3;
    exp[5] = 32'hFFFFFFF7;
    exp[6] = 32'h00000008;
    exp[7] = 32'h00002800;
    exp[8] = 32'hFFFFFFFE;
    pulse_reset();
    start = 1;
    repeat (5) tick();
    for (int i = 4; i <= 8; i++) begin
      n_checks++;
      if (dut.Registers.register[i] !== exp[i]) begin
        n_errors++;
        $display("FAIL alu_x%0d: got %h expected %h", i, dut.Registers.register[i], exp[i]);
      end
    end
  endtask

  task automatic test_mul();
    logic [31:0] exp9;
    start = 0;
    clear_rom();
    clear_regs();
    set_reg(1, 32'd10);
    set_reg(2, 32'hFFFFFFFD);
    set_reg(9, 32'h12345678);
    put(0, r_type(7'b0000001, 5'd2, 5'd1, 3'd0, 5'd9));
`ifdef CPU_MUL_EN
    exp9 = 32'hFFFFFFE2;
`else
    exp9 = 32'h12345678;
`endif
    pulse_reset();
    start = 1;
    tick();
    n_checks++;
    if (dut.Registers.register[9] !== exp9) begin
      n_errors++;
      $display("FAIL mul_x9: got %h expected %h", dut.Registers.register[9], exp9);
    end
  endtask

  task automatic test_x0_nop();
    logic [31:0] snap [32];
    start = 0;
    clear_rom();
    clear_regs();
    for (int i = 1; i < 32; i++) set_reg(i, $urandom);
    for (int i = 0; i < 32; i++) snap[i] = m_reg[i];
    put(0, i_type(12'd5, 5'd0, 3'd0, 5'd0));
    put(1, 32'hFFFFFFFF);
    pulse_reset();
    start = 1;
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_checks++;
      if (dut.PC.pc_o !== 32'(4 * k)) begin
        n_errors++;
        $display("FAIL nop_pc%0d: got %h expected %h", k, dut.PC.pc_o, 32'(4 * k));
      end
    end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (dut.Registers.register[i] !== snap[i]) begin
        n_errors++;
        $display("FAIL nop_x%0d: got %h expected %h", i, dut.Registers.register[i], snap[i]);
      end
    end
  endtask

  task automatic test_start_hold();
    logic [31:0] pc_hold;
    start = 0;
    clear_rom();
    clear_regs();
    for (int i = 0; i < 16; i++) put(i, i_type(12'd1, 5'd1, 3'd0, 5'd1));
    pulse_reset();
    start = 1;
    repeat (2) tick();
    start = 0;
    pc_hold = 32'd8;
    repeat (3) tick();
    n_checks++;
    if (dut.PC.pc_o !== pc_hold) begin
      n_errors++; $display("FAIL hold_pc: got %h expected %h", dut.PC.pc_o, pc_hold);
    end
    n_checks++;
    if (dut.Registers.register[1] !== 32'd2) begin
      n_errors++; $display("FAIL hold_x1: got %h expected 00000002", dut.Registers.register[1]);
    end
    start = 1;
    repeat (3) tick();
    n_checks++;
    if (dut.Registers.register[1] !== 32'd5 || dut.PC.pc_o !== 32'd20) begin
      n_errors++;
      $display("FAIL resume: x1 %h pc %h expected x1 00000005 pc 00000014",
               dut.Registers.register[1], dut.PC.pc_o);
    end
    // Mid-cycle reset: PC clears at once, registers keep their contents
    rst = 1;
    #1;
    n_checks++;
    if (dut.PC.pc_o !== 32'd0) begin
      n_errors++; $display("FAIL midreset_pc: got %h expected 00000000", dut.PC.pc_o);
    end
    n_checks++;
    if (dut.Registers.register[1] !== 32'd5) begin
      n_errors++; $display("FAIL midreset_x1: got %h expected 00000005", dut.Registers.register[1]);
    end
    #1;
    rst = 0;
    m_pc = 0;
    tick();
    n_checks++;
    if (dut.PC.pc_o !== 32'd4 || dut.Registers.register[1] !== 32'd6) begin
      n_errors++;
      $display("FAIL after_reset: pc %h x1 %h expected pc 00000004 x1 00000006",
               dut.PC.pc_o, dut.Registers.register[1]);
    end
  endtask

  task automatic test_random();
    logic [31:0] w;
    logic [4:0]  rd, r1, r2;
    start = 0;
    clear_rom();
    clear_regs();
    for (int i = 1; i < 32; i++) set_reg(i, $urandom);
    for (int i = 0; i < 256; i++) begin
      rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
      case ($urandom_range(0, 8))
        0: w = r_type(7'b0000000, r2, r1, 3'd7, rd);
        1: w = r_type(7'b0000000, r2, r1, 3'd4, rd);
        2: w = r_type(7'b0000000, r2, r1, 3'd1, rd);
        3: w = r_type(7'b0000000, r2, r1, 3'd0, rd);
        4: w = r_type(7'b0100000, r2, r1, 3'd0, rd);
        5: w = r_type(7'b0000001, r2, r1, 3'd0, rd);
        6: w = i_type(12'($urandom), r1, 3'd0, rd);
        7: w = i_type({7'b0100000, r2}, r1, 3'd5, rd);
        default: w = $urandom;
      endcase
      put(i, w);
    end
    pulse_reset();
    for (int cyc = 0; cyc < 320; cyc++) begin
      start = ($urandom_range(0, 9) != 0);
      tick();
      n_checks++;
      if (dut.PC.pc_o !== m_pc) begin
        n_errors++;
        $display("FAIL rand_pc cyc%0d: got %h expected %h", cyc, dut.PC.pc_o, m_pc);
      end
      for (int i = 0; i < 32; i++) begin
        n_checks++;
        if (dut.Registers.register[i] !== m_reg[i]) begin
          n_errors++;
          $display("FAIL rand_x%0d cyc%0d: got %h expected %h", i, cyc,
                   dut.Registers.register[i], m_reg[i]);
        end
      end
    end
  endtask

  initial begin
    clk   = 0;
    rst   = 1;
    start = 0;
    m_pc  = 0;
    clear_rom();
    clear_regs();
    test_reset();
    test_pc_progression();
    test_addi_add();
    test_alu_ops();
    test_mul();
    test_x0_nop();
    test_start_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
